// File: rtl/axi4_slave_mem_responder.sv
// axi4_slave_mem_responder: AXI4 slave backed by an internal word memory, independent write and read paths
module axi4_slave_mem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr, input logic [ADDR_WIDTH-1:0] start,
                                                      input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] b, w, base;
    b = ONE << size;
    w = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
    base = start & ~(w - ONE);
    next_addr = burst == 2'b01 ? (addr & ~(b - ONE)) + b :
                burst == 2'b10 ? base + ((addr + b - base) & (w - ONE)) : addr;
  endfunction
  function automatic logic bad_burst(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    bad_burst = size > 3'(LSB) || burst == 2'b11 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
  function automatic logic oob(input logic [ADDR_WIDTH-1:0] addr);
    oob = (addr >> LSB) >= ADDR_WIDTH'(MEM_DEPTH);
  endfunction
  w_state_t w_state, w_nxt;
  logic [ID_WIDTH-1:0] w_id;
  logic [ADDR_WIDTH-1:0] w_addr, w_start;
  logic [7:0] w_len, w_cnt;
  logic [2:0] w_size;
  logic [1:0] w_burst;
  logic w_bad, w_err, aw_fire, w_fire, w_end, w_oob;
  logic [IW-1:0] w_idx;
  assign aw_fire = awvalid && awready;
  assign w_fire = wvalid && wready;
  assign w_end = w_cnt == w_len;
  assign w_oob = oob(w_addr);
  assign w_idx = w_addr[LSB +: IW];
  // write FSM state register
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) w_state <= W_IDLE;
    else w_state <= w_nxt;
  // write FSM next state: address, data beats up to len, then response
  always_comb begin
    w_nxt = w_state;
    case (w_state)
      W_IDLE: if (awvalid) w_nxt = W_DATA;
      W_DATA: if (wvalid && w_end) w_nxt = W_RESP;
      W_RESP: if (bready) w_nxt = W_IDLE;
      default: w_nxt = W_IDLE;
    endcase
  end
  // write channel outputs; ready is gated so reset drops it immediately
  always_comb begin
    awready = aresetn && w_state == W_IDLE;
    wready = w_state == W_DATA;
    bvalid = w_state == W_RESP;
    bresp = bvalid && w_err ? 2'b10 : 2'b00;
    bid = w_id;
  end
  // write burst tracking: capture on AW, step address and accumulate errors per beat
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      w_id <= '0;
      w_addr <= '0;
      w_start <= '0;
      w_len <= '0;
      w_size <= '0;
      w_burst <= '0;
      w_cnt <= '0;
      w_bad <= 1'b0;
      w_err <= 1'b0;
    end else if (aw_fire) begin
      w_id <= awid;
      w_addr <= awaddr;
      w_start <= awaddr;
      w_len <= awlen;
      w_size <= awsize;
      w_burst <= awburst;
      w_cnt <= '0;
      w_bad <= bad_burst(awlen, awsize, awburst);
      w_err <= bad_burst(awlen, awsize, awburst);
    end else if (w_fire) begin
      w_addr <= next_addr(w_addr, w_start, w_len, w_size, w_burst);
      w_cnt <= w_cnt + 8'd1;
      if (w_oob || wlast != w_end) w_err <= 1'b1;
    end
  // commit strobed bytes of accepted beats that are in range and from a legal burst
  always_ff @(posedge aclk)
    if (w_fire && !w_bad && !w_oob)
      for (int i = 0; i < NB; i++)
        if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
  r_state_t r_state, r_nxt;
  logic [ID_WIDTH-1:0] r_id;
  logic [ADDR_WIDTH-1:0] r_addr, r_start, ld_addr;
  logic [7:0] r_len, r_cnt;
  logic [2:0] r_size;
  logic [1:0] r_burst;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0] r_resp;
  logic r_bad, ar_fire, r_fire, r_end, ld, ld_err;
  logic [IW-1:0] ld_idx;
  assign ar_fire = arvalid && arready;
  assign r_fire = rvalid && rready;
  assign r_end = r_cnt == r_len;
  assign ld = ar_fire || (r_fire && !r_end);
  assign ld_addr = ar_fire ? araddr : next_addr(r_addr, r_start, r_len, r_size, r_burst);
  assign ld_err = (ar_fire ? bad_burst(arlen, arsize, arburst) : r_bad) || oob(ld_addr);
  assign ld_idx = ld_addr[LSB +: IW];
  // read FSM state register
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) r_state <= R_IDLE;
    else r_state <= r_nxt;
  // read FSM next state: leave data phase on the handshake of the last beat
  always_comb begin
    r_nxt = r_state;
    case (r_state)
      R_IDLE: if (arvalid) r_nxt = R_DATA;
      R_DATA: if (rready && r_end) r_nxt = R_IDLE;
      default: r_nxt = R_IDLE;
    endcase
  end
  // read channel outputs
  always_comb begin
    arready = aresetn && r_state == R_IDLE;
    rvalid = r_state == R_DATA;
    rlast = rvalid && r_end;
    rid = r_id;
    rdata = r_data;
    rresp = r_resp;
  end
  // read burst: beat 0 loads on AR, each later beat loads on the previous R handshake
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_id <= '0;
      r_addr <= '0;
      r_start <= '0;
      r_len <= '0;
      r_size <= '0;
      r_burst <= '0;
      r_cnt <= '0;
      r_bad <= 1'b0;
      r_data <= '0;
      r_resp <= '0;
    end else begin
      if (ar_fire) begin
        r_id <= arid;
        r_start <= araddr;
        r_len <= arlen;
        r_size <= arsize;
        r_burst <= arburst;
        r_cnt <= '0;
        r_bad <= bad_burst(arlen, arsize, arburst);
      end else if (r_fire && !r_end) r_cnt <= r_cnt + 8'd1;
      if (ld) begin
        r_addr <= ld_addr;
        r_data <= ld_err ? '0 : mem[ld_idx];
        r_resp <= ld_err ? 2'b10 : 2'b00;
      end
    end
endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// tb_axi4_slave_mem_responder: table-driven scoreboard bench for the AXI4 memory responder
module tb_axi4_slave_mem_responder;
  logic aclk = 0, aresetn = 0;
  logic [3:0] awid = 0, arid = 0, bid, rid, wstrb = 0;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
  logic [7:0] awlen = 0, arlen = 0;
  logic [2:0] awsize = 0, arsize = 0;
  logic [1:0] awburst = 0, arburst = 0, bresp, rresp;
  logic awvalid = 0, wlast = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic awready, wready, bvalid, arready, rlast, rvalid;
  always #5 aclk = ~aclk;
  axi4_slave_mem_responder dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );
  typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; bit chk; } rexp_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { bit wr; logic [3:0] id; logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
                   logic [31:0] dbase; int sbeat; logic [3:0] sval; int lbeat; logic [1:0] bresp; bit toggle; } vec_t;
  rexp_t rq[$];
  bexp_t bq[$];
  logic [31:0] mem_m [1024];
  bit known [1024];
  int n_vec = 0, n_err = 0;
  bit r_mon = 1, rtoggle = 0;
  vec_t tbl[21];
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask
  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [7:0] len, input logic [2:0] size,
                                            input logic [1:0] burst, input int i);
    logic [31:0] b, w, base;
    b = 32'd1 << size;
    w = (32'(len) + 1) * b;
    base = start & ~(w - 1);
    if (burst == 2'b01) return i == 0 ? start : (start & ~(b - 1)) + 32'(i) * b;
    if (burst == 2'b10) return base + ((start - base + 32'(i) * b) % w);
    return start;
  endfunction
  function automatic bit legal(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
    return size <= 3'd2 && burst != 2'b11 && !(burst == 2'b10 && len != 1 && len != 3 && len != 7 && len != 15);
  endfunction
  always @(posedge aclk) begin
    #1;
    rready = rtoggle ? !rready : 1'b1;
  end
  always @(negedge aclk)
    if (aresetn && bvalid && bready) begin
      bexp_t e;
      if (bq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL b_unexpected: got bid %h, required no response", bid);
      end else begin
        e = bq.pop_front();
        check("bid", 32'(bid), 32'(e.id));
        check("bresp", 32'(bresp), 32'(e.resp));
      end
    end
  always @(negedge aclk)
    if (r_mon && aresetn && rvalid && rready) begin
      rexp_t e;
      if (rq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL r_unexpected: got rid %h, required no beat", rid);
      end else begin
        e = rq.pop_front();
        check("rid", 32'(rid), 32'(e.id));
        if (e.chk) check("rdata", rdata, e.data);
        check("rresp", 32'(rresp), 32'(e.resp));
        check("rlast", 32'(rlast), 32'(e.last));
      end
    end
  task automatic wait_ready(input int sel);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 100) begin
      @(negedge aclk);
      hit = sel == 0 ? awready : sel == 1 ? wready : arready;
      n++;
    end
    if (!hit) fail(sel == 0 ? "awready_wait" : sel == 1 ? "wready_wait" : "arready_wait");
    @(posedge aclk);
    #1;
  endtask
  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [31:0] dbase, input int sbeat, input logic [3:0] sval,
                             input int lbeat, input logic [1:0] resp);
    bexp_t e;
    e.id = id;
    e.resp = resp;
    bq.push_back(e);
    @(posedge aclk);
    #1;
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    wait_ready(0);
    awvalid = 0;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] a;
      wvalid = 1;
      wdata = dbase + 32'(i);
      wstrb = i == sbeat ? sval : 4'hF;
      wlast = i == (lbeat < 0 ? int'(len) : lbeat);
      wait_ready(1);
      a = beat_addr(addr, len, size, burst, i);
      if (legal(len, size, burst) && a < 32'h1000) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem_m[a[11:2]][8*b +: 8] = wdata[8*b +: 8];
        known[a[11:2]] = 1;
      end
    end
    wvalid = 0;
    wlast = 0;
  endtask
  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      logic [31:0] a;
      a = beat_addr(addr, len, size, burst, i);
      e.id = id;
      e.last = i == int'(len);
      if (legal(len, size, burst) && a < 32'h1000) begin
        e.resp = 2'b00;
        e.data = mem_m[a[11:2]];
        e.chk = known[a[11:2]];
      end else begin
        e.resp = 2'b10;
        e.data = 0;
        e.chk = 1;
      end
      rq.push_back(e);
    end
    @(posedge aclk);
    #1;
    arvalid = 1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    wait_ready(2);
    arvalid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      fail("drain");
      rq.delete();
      bq.delete();
    end
  endtask
  initial begin
    int beats, n;
    tbl[0]  = '{1, 4'h1, 32'h010, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, -1, 4'hF, -1, 2'b00, 0};
    tbl[1]  = '{0, 4'h2, 32'h010, 8'd0, 3'd2, 2'b01, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    tbl[2]  = '{1, 4'h3, 32'h100, 8'd15, 3'd2, 2'b01, 32'hA0000000, -1, 4'hF, -1, 2'b00, 0};
    tbl[3]  = '{1, 4'h4, 32'h030, 8'd7, 3'd2, 2'b01, 32'hC0000000, -1, 4'hF, -1, 2'b00, 0};
    tbl[4]  = '{1, 4'h5, 32'h100, 8'd3, 3'd2, 2'b01, 32'h1, 2, 4'h3, -1, 2'b00, 0};
    tbl[5]  = '{0, 4'h6, 32'h100, 8'd3, 3'd2, 2'b01, 32'h0, -1, 4'hF, -1, 2'b00, 1};
    tbl[6]  = '{0, 4'h7, 32'h038, 8'd3, 3'd2, 2'b10, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    tbl[7]  = '{1, 4'h8, 32'h000, 8'd0, 3'd2, 2'b01, 32'h12345678, -1, 4'hF, -1, 2'b00, 0};
    tbl[8]  = '{1, 4'h8, 32'h1000, 8'd0, 3'd2, 2'b01, 32'h55, -1, 4'hF, -1, 2'b10, 0};
    tbl[9]  = '{0, 4'h9, 32'h000, 8'd0, 3'd2, 2'b01, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    tbl[10] = '{1, 4'h9, 32'h200, 8'd3, 3'd2, 2'b01, 32'h20, -1, 4'hF, 1, 2'b10, 0};
    tbl[11] = '{1, 4'hA, 32'h040, 8'd0, 3'd3, 2'b01, 32'h77, -1, 4'hF, -1, 2'b10, 0};
    tbl[12] = '{0, 4'hB, 32'h040, 8'd0, 3'd2, 2'b01, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    tbl[13] = '{0, 4'hC, 32'h100, 8'd2, 3'd2, 2'b10, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    tbl[14] = '{1, 4'hD, 32'hFFC, 8'd1, 3'd2, 2'b01, 32'hE0, -1, 4'hF, -1, 2'b10, 0};
    tbl[15] = '{0, 4'hE, 32'hFFC, 8'd1, 3'd2, 2'b01, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    tbl[16] = '{1, 4'hF, 32'h050, 8'd2, 3'd2, 2'b00, 32'h90, -1, 4'hF, -1, 2'b00, 0};
    tbl[17] = '{0, 4'h1, 32'h050, 8'd1, 3'd2, 2'b00, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    tbl[18] = '{0, 4'h2, 32'h100, 8'd3, 3'd1, 2'b01, 32'h0, -1, 4'hF, -1, 2'b00, 1};
    tbl[19] = '{1, 4'h3, 32'h300, 8'd3, 3'd2, 2'b01, 32'hB0, -1, 4'hF, -1, 2'b00, 0};
    tbl[20] = '{0, 4'h4, 32'h010, 8'd0, 3'd2, 2'b11, 32'h0, -1, 4'hF, -1, 2'b00, 0};
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rlast", 32'(rlast), 0);
    check("rst_rdata", rdata, 0);
    @(negedge aclk);
    aresetn = 1;
    #1;
    check("rel_awready", 32'(awready), 1);
    check("rel_arready", 32'(arready), 1);
    foreach (tbl[k]) begin
      rtoggle = tbl[k].toggle;
      if (tbl[k].wr)
        write_burst(tbl[k].id, tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst, tbl[k].dbase,
                    tbl[k].sbeat, tbl[k].sval, tbl[k].lbeat, tbl[k].bresp);
      else
        read_burst(tbl[k].id, tbl[k].addr, tbl[k].len, tbl[k].size, tbl[k].burst);
      drain();
      rtoggle = 0;
    end
    bready = 0;
    fork
      read_burst(4'h6, 32'h300, 8'd3, 3'd2, 2'b01);
      write_burst(4'h7, 32'h300, 8'd3, 3'd2, 2'b01, 32'hD0, -1, 4'hF, -1, 2'b00);
    join
    repeat (5) begin
      @(negedge aclk);
      check("bvalid_held", 32'(bvalid), 1);
      check("awready_blocked", 32'(awready), 0);
    end
    @(posedge aclk);
    #1;
    bready = 1;
    drain();
    read_burst(4'h8, 32'h300, 8'd0, 3'd2, 2'b01);
    drain();
    r_mon = 0;
    @(posedge aclk);
    #1;
    arvalid = 1; arid = 4'h5; araddr = 32'h100; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01;
    wait_ready(2);
    arvalid = 0;
    beats = 0;
    n = 0;
    while (beats < 2 && n < 50) begin
      @(negedge aclk);
      if (rvalid && rready) beats++;
      n++;
    end
    if (beats < 2) fail("reset_beats");
    @(posedge aclk);
    #2;
    check("pre_rst_rvalid", 32'(rvalid), 1);
    aresetn = 0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 0);
    check("mid_rst_arready", 32'(arready), 0);
    check("mid_rst_awready", 32'(awready), 0);
    check("mid_rst_rlast", 32'(rlast), 0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1;
    #1;
    check("post_rst_arready", 32'(arready), 1);
    check("post_rst_rvalid", 32'(rvalid), 0);
    r_mon = 1;
    read_burst(4'h9, 32'h100, 8'd0, 3'd2, 2'b01);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
